// File: rtl/instruction_fetch.sv
// Single-outstanding instruction fetch unit: requests one word at the latched PC,
// holds it in the IR until decode accepts it, and aborts on a stuck memory.
module instruction_fetch #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fetch_en,
    input  logic                     flush,
    input  logic [ADDR_W-1:0]        pc,
    output logic                     mem_req,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic                     mem_ack,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic                     ir_valid,
    input  logic                     ir_ready,
    output logic [DATA_W-ADDR_W-1:0] ir_opcode,
    output logic [ADDR_W-1:0]        ir_operand,
    output logic [ADDR_W-1:0]        ir_pc,
    output logic                     fetch_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_FULL = 2'd2;

    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_ir;
    logic [ADDR_W-1:0] r_ir_pc;
    logic [7:0]        r_cnt;
    logic              r_err;

    logic              w_timeout;

    assign w_timeout = (r_cnt == TO_LIMIT);

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_ir    <= '0;
            r_ir_pc <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else if (flush) begin
            // Flush wins over ack/ready/fetch_en; any data captured this cycle is dropped.
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (fetch_en) begin
                        r_addr  <= pc;
                        r_cnt   <= '0;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        r_ir    <= mem_rdata;
                        r_ir_pc <= r_addr;
                        r_cnt   <= '0;
                        r_state <= S_FULL;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt   <= r_cnt + 8'd1;
                    end
                end
                S_FULL: begin
                    if (ir_ready) begin
                        if (fetch_en) begin
                            r_addr  <= pc;
                            r_state <= S_REQ;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_req    = (r_state == S_REQ);
    assign mem_addr   = r_addr;
    assign ir_valid   = (r_state == S_FULL);
    assign ir_opcode  = r_ir[DATA_W-1:ADDR_W];
    assign ir_operand = r_ir[ADDR_W-1:0];
    assign ir_pc      = r_ir_pc;
    assign fetch_err  = r_err;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: directed corner cases plus randomized
// fetch traffic checked against a memory-lookup reference model.
module tb_instruction_fetch;

    localparam int AW = 5;
    localparam int DW = 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [AW-1:0] pc;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          fetch_en;
    logic          flush;
    logic [AW-1:0] pc;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic          ir_valid;
    logic          ir_ready;
    logic [DW-AW-1:0] ir_opcode;
    logic [AW-1:0] ir_operand;
    logic [AW-1:0] ir_pc;
    logic          fetch_err;

    logic [DW-1:0] mem [32];
    exp_t          exp_q [$];

    int n_checks  = 0;
    int n_errors  = 0;
    int req_count = 0;
    int wait_lo   = 0;
    int wait_hi   = 0;
    bit auto_ack  = 1'b0;
    bit ack_en    = 1'b1;
    bit rand_ready = 1'b0;

    instruction_fetch #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(15)) dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_en   (fetch_en),
        .flush      (flush),
        .pc         (pc),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .ir_valid   (ir_valid),
        .ir_ready   (ir_ready),
        .ir_opcode  (ir_opcode),
        .ir_operand (ir_operand),
        .ir_pc      (ir_pc),
        .fetch_err  (fetch_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_mem_req"},    32'(mem_req),    0);
        check({tag, "_mem_addr"},   32'(mem_addr),   0);
        check({tag, "_ir_valid"},   32'(ir_valid),   0);
        check({tag, "_ir_opcode"},  32'(ir_opcode),  0);
        check({tag, "_ir_operand"}, 32'(ir_operand), 0);
        check({tag, "_ir_pc"},      32'(ir_pc),      0);
        check({tag, "_fetch_err"},  32'(fetch_err),  0);
    endtask

    // Reference model: a fetch launched from address p delivers mem[p] tagged with p.
    task automatic push_exp(input logic [AW-1:0] p);
        exp_q.push_back('{data: mem[p], pc: p});
    endtask

    // Memory responder: counts new requests, checks address stability, acks after a wait.
    initial begin
        logic          prev_req;
        logic [AW-1:0] addr0;
        int            wcnt;
        int            wtarget;
        prev_req = 1'b0;
        addr0    = '0;
        wcnt     = 0;
        wtarget  = 0;
        forever begin
            @(negedge clk);
            if (mem_req && !prev_req) begin
                req_count++;
                addr0   = mem_addr;
                wcnt    = 0;
                wtarget = wait_lo + int'($urandom_range(0, wait_hi - wait_lo));
            end else if (mem_req) begin
                check("mem_addr_stable", 32'(mem_addr), 32'(addr0));
            end
            if (auto_ack) begin
                if (mem_req && ack_en && wcnt == wtarget) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem[mem_addr];
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = 8'($urandom);
                end
                if (mem_req) wcnt++;
            end
            prev_req = mem_req;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rand_ready) ir_ready = ($urandom_range(0, 9) < 6);
        end
    end

    // Monitor: every accepted instruction must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && !flush && ir_valid && ir_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL ir_unexpected: got pc=0x%0h op=0x%0h operand=0x%0h expected nothing",
                             ir_pc, ir_opcode, ir_operand);
                end else begin
                    e = exp_q.pop_front();
                    check("ir_accept", 32'({ir_opcode, ir_operand, ir_pc}), 32'({e.data, e.pc}));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int            n;
        int            base;
        logic [AW-1:0] p;

        rst = 1'b1; fetch_en = 1'b0; flush = 1'b0; pc = '0;
        mem_ack = 1'b0; mem_rdata = '0; ir_ready = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
        mem[3] = 8'hA7;

        repeat (2) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        auto_ack = 1'b1;

        // Basic zero-wait fetch
        pc = 5'h03; fetch_en = 1'b1; push_exp(5'h03);
        @(negedge clk);
        check("basic_mem_req",  32'(mem_req),  1);
        check("basic_mem_addr", 32'(mem_addr), 3);
        fetch_en = 1'b0; pc = 5'h09;
        @(negedge clk);
        check("basic_ir_valid",   32'(ir_valid),   1);
        check("basic_ir_opcode",  32'(ir_opcode),  32'h5);
        check("basic_ir_operand", 32'(ir_operand), 32'h07);
        check("basic_ir_pc",      32'(ir_pc),      3);
        ir_ready = 1'b1;
        @(negedge clk);
        check("basic_idle_after_accept", 32'(ir_valid), 0);
        ir_ready = 1'b0;

        // Backpressure with a changing pc, then back-to-back launch
        pc = 5'd10; fetch_en = 1'b1; push_exp(5'd10);
        @(negedge clk);
        fetch_en = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            pc = 5'($urandom);
            @(negedge clk);
            check("bp_ir_valid", 32'(ir_valid), 1);
            check("bp_mem_req",  32'(mem_req),  0);
            check("bp_ir",       32'({ir_opcode, ir_operand, ir_pc}), 32'({mem[10], 5'd10}));
        end
        pc = 5'd17; fetch_en = 1'b1; ir_ready = 1'b1; push_exp(5'd17);
        @(negedge clk);
        check("bp_next_mem_req",  32'(mem_req),  1);
        check("bp_next_mem_addr", 32'(mem_addr), 17);
        fetch_en = 1'b0;
        repeat (3) @(negedge clk);
        ir_ready = 1'b0;

        // Three wait states with pc changing under the request
        wait_lo = 3; wait_hi = 3;
        pc = 5'd20; fetch_en = 1'b1; push_exp(5'd20);
        n = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            fetch_en = 1'b0;
            pc = 5'($urandom);
            if (ir_valid) break;
            if (mem_req) n++;
        end
        check("wait_req_cycles", 32'(n), 4);
        check("wait_ir", 32'({ir_valid, ir_opcode, ir_operand, ir_pc}), 32'({1'b1, mem[20], 5'd20}));
        ir_ready = 1'b1;
        @(negedge clk);
        ir_ready = 1'b0;
        wait_lo = 0; wait_hi = 0;

        // Timeout: memory never acks
        ack_en = 1'b0;
        pc = 5'd5; fetch_en = 1'b1;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            fetch_en = 1'b0;
            if (mem_req) n++;
            else if (n > 0) break;
        end
        check("timeout_req_cycles", 32'(n), 16);
        check("timeout_err", 32'(fetch_err), 1);
        repeat (3) @(negedge clk);
        check("timeout_err_sticky", 32'({fetch_err, mem_req}), 32'b10);
        ack_en = 1'b1;
        pc = 5'd6; fetch_en = 1'b1; push_exp(5'd6);
        @(negedge clk);
        fetch_en = 1'b0;
        @(negedge clk);
        check("post_timeout_valid", 32'(ir_valid), 1);
        ir_ready = 1'b1;
        @(negedge clk);
        ir_ready = 1'b0;
        check("post_timeout_err", 32'(fetch_err), 1);

        // Flush colliding with ack, then a late ack in IDLE
        auto_ack = 1'b0; mem_ack = 1'b0;
        pc = 5'd7; fetch_en = 1'b1;
        @(negedge clk);
        check("flush_in_req", 32'(mem_req), 1);
        fetch_en = 1'b0; flush = 1'b1; mem_ack = 1'b1; mem_rdata = 8'hFF;
        @(negedge clk);
        check("flush_collide", 32'({ir_valid, mem_req}), 0);
        flush = 1'b0;
        @(negedge clk);
        check("late_ack_ignored", 32'({ir_valid, mem_req}), 0);
        mem_ack = 1'b0;

        // Flush while FULL, coincident with ir_ready
        pc = 5'd8; fetch_en = 1'b1;
        @(negedge clk);
        fetch_en = 1'b0; mem_ack = 1'b1; mem_rdata = mem[8];
        @(negedge clk);
        check("flush_full_valid", 32'(ir_valid), 1);
        mem_ack = 1'b0; flush = 1'b1; ir_ready = 1'b1;
        @(negedge clk);
        check("flush_full_dropped", 32'({ir_valid, mem_req}), 0);
        flush = 1'b0; ir_ready = 1'b0;

        // Reset during REQ with a coincident ack, and during FULL
        pc = 5'd11; fetch_en = 1'b1;
        @(negedge clk);
        fetch_en = 1'b0; rst = 1'b1; mem_ack = 1'b1; mem_rdata = 8'h5A;
        @(negedge clk);
        check_reset("rst_req");
        rst = 1'b0; mem_ack = 1'b0;
        pc = 5'd12; fetch_en = 1'b1;
        @(negedge clk);
        fetch_en = 1'b0; mem_ack = 1'b1; mem_rdata = 8'hC3;
        @(negedge clk);
        check("rst_full_valid", 32'(ir_valid), 1);
        mem_ack = 1'b0; rst = 1'b1;
        @(negedge clk);
        check_reset("rst_full");
        rst = 1'b0;

        // Randomized traffic: random gaps, wait states and decode backpressure
        auto_ack = 1'b1; wait_lo = 0; wait_hi = 3; rand_ready = 1'b1;
        for (int t = 0; t < 150; t++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            p = 5'($urandom);
            pc = p; fetch_en = 1'b1;
            base = req_count;
            for (int c = 0; c < 100 && req_count == base; c++) @(negedge clk);
            check("launch_seen", 32'(req_count != base), 1);
            push_exp(p);
            fetch_en = 1'b0;
            pc = 5'($urandom);
        end
        rand_ready = 1'b0; ir_ready = 1'b1;
        for (int c = 0; c < 100 && exp_q.size() != 0; c++) @(negedge clk);
        @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
